// File: rtl/sadd_sched.sv
// Sequencer for a mux-based scaled stochastic adder.
// Sobol (bit-reversed) select order with valid/first/last/done framing.
module sadd_sched #(
  parameter int INUM    = 8,
  parameter int LOGINUM = 3,
  parameter int LENW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LENW-1:0]    len,
  input  logic               stall,
  input  logic               abort,
  output logic               busy,
  output logic               valid,
  output logic [LOGINUM-1:0] sel,
  output logic               first,
  output logic               last,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [LOGINUM-1:0] phase;
  logic [LENW-1:0]    count;
  logic [LENW-1:0]    len_q;
  logic [LENW-1:0]    last_cnt;
  logic [LOGINUM-1:0] phase_rev;
  logic               run;
  logic               at_last;

  // len_q of 0 wraps to all-ones, giving a 2**LENW stream
  assign last_cnt = len_q - 1'b1;
  assign run      = (state == RUN);
  assign at_last  = (count == last_cnt);

  always_comb begin
    phase_rev = '0;
    for (int i = 0; i < LOGINUM; i++)
      phase_rev[i] = phase[LOGINUM-1-i];
  end

  assign busy  = (state != IDLE);
  assign valid = run & ~stall & ~abort;
  assign sel   = run ? phase_rev : '0;
  assign first = valid & (count == '0);
  assign last  = valid & at_last;
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      count <= '0;
      len_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            len_q <= len;
            count <= '0;
            phase <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (!stall) begin
            count <= count + 1'b1;
            phase <= phase + 1'b1;
            if (at_last)
              state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sadd_sched.sv
// Directed bench for sadd_sched.
// Vectors pack {busy,valid,first,last,done,sel}.
module tb_sadd_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       stall;
  logic       abort;
  logic       busy;
  logic       valid;
  logic [2:0] sel;
  logic       first;
  logic       last;
  logic       done;

  int checks;
  int failures;

  sadd_sched #(.INUM(8), .LOGINUM(3), .LENW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .stall (stall),
    .abort (abort),
    .busy  (busy),
    .valid (valid),
    .sel   (sel),
    .first (first),
    .last  (last),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pk(input logic b, input logic v,
                                    input logic f, input logic l,
                                    input logic d, input logic [2:0] s);
    return {b, v, f, l, d, s};
  endfunction

  // Drive one cycle, check outputs mid-cycle, then advance.
  // sel is not checked on done cycles.
  task automatic cyc(input string tag, input logic s,
                     input logic [7:0] l, input logic st,
                     input logic ab, input logic [7:0] exp);
    logic [7:0] obs;
    start = s;
    len   = l;
    stall = st;
    abort = ab;
    #1;
    obs = {busy, valid, first, last, done, sel};
    if (exp[3])
      check(tag, {27'd0, obs[7:3]}, {27'd0, exp[7:3]});
    else
      check(tag, {24'd0, obs}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] ZERO = 8'h00;

  initial begin
    int sob [8];
    int hist [8];
    int nvalid, ndone, nfirst, nlast, lastidx;
    logic [7:0] e;
    sob = '{0, 4, 2, 6, 1, 5, 3, 7};
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b1;
    len = 8'd8;
    stall = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic len=8 stream
    cyc("t1_start", 1, 8, 0, 0, ZERO);
    for (int i = 0; i < 8; i++) begin
      e = pk(1, 1, i == 0, i == 7, 0, 3'(sob[i]));
      cyc($sformatf("t1_v%0d", i), 0, 8, 0, 0, e);
    end
    cyc("t1_done", 0, 8, 0, 0, pk(1, 0, 0, 0, 1, 0));
    cyc("t1_idle", 0, 8, 0, 0, ZERO);

    // len=0 means 256 cycles
    foreach (hist[i]) hist[i] = 0;
    nvalid = 0; ndone = 0; nfirst = 0; nlast = 0; lastidx = -1;
    start = 1'b1; len = 8'd0; stall = 1'b0; abort = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (valid) begin
        hist[sel]++;
        nvalid++;
      end
      if (first) nfirst++;
      if (last) begin
        nlast++;
        lastidx = nvalid;
      end
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    check("t2_nvalid", nvalid, 256);
    check("t2_ndone", ndone, 1);
    check("t2_nfirst", nfirst, 1);
    check("t2_lastidx", lastidx, 256);
    for (int i = 0; i < 8; i++)
      check($sformatf("t2_hist%0d", i), hist[i], 32);

    // len=5 with stall on RUN cycles 2 and 3
    cyc("t3_start", 1, 5, 0, 0, ZERO);
    cyc("t3_r1", 0, 5, 0, 0, pk(1, 1, 1, 0, 0, 0));
    cyc("t3_s1", 0, 5, 1, 0, pk(1, 0, 0, 0, 0, 4));
    cyc("t3_s2", 0, 5, 1, 0, pk(1, 0, 0, 0, 0, 4));
    cyc("t3_r4", 0, 5, 0, 0, pk(1, 1, 0, 0, 0, 4));
    cyc("t3_r5", 0, 5, 0, 0, pk(1, 1, 0, 0, 0, 2));
    cyc("t3_r6", 0, 5, 0, 0, pk(1, 1, 0, 0, 0, 6));
    cyc("t3_r7", 0, 5, 0, 0, pk(1, 1, 0, 1, 0, 1));
    cyc("t3_done", 0, 5, 0, 0, pk(1, 0, 0, 0, 1, 0));
    cyc("t3_idle", 0, 5, 0, 0, ZERO);

    // abort with stall in 4th valid cycle
    cyc("t4_start", 1, 8, 0, 0, ZERO);
    cyc("t4_v0", 0, 8, 0, 0, pk(1, 1, 1, 0, 0, 0));
    cyc("t4_v1", 0, 8, 0, 0, pk(1, 1, 0, 0, 0, 4));
    cyc("t4_v2", 0, 8, 0, 0, pk(1, 1, 0, 0, 0, 2));
    cyc("t4_abort", 0, 8, 1, 1, pk(1, 0, 0, 0, 0, 6));
    cyc("t4_idle0", 0, 8, 0, 0, ZERO);
    cyc("t4_idle1", 0, 8, 0, 0, ZERO);

    // start held high, len=3
    cyc("t5_start", 1, 3, 0, 0, ZERO);
    cyc("t5_a0", 1, 3, 0, 0, pk(1, 1, 1, 0, 0, 0));
    cyc("t5_a1", 1, 3, 0, 0, pk(1, 1, 0, 0, 0, 4));
    cyc("t5_a2", 1, 3, 0, 0, pk(1, 1, 0, 1, 0, 2));
    cyc("t5_adone", 1, 3, 0, 0, pk(1, 0, 0, 0, 1, 0));
    cyc("t5_idle", 1, 3, 0, 0, ZERO);
    cyc("t5_b0", 0, 3, 0, 0, pk(1, 1, 1, 0, 0, 0));
    cyc("t5_b1", 0, 3, 0, 0, pk(1, 1, 0, 0, 0, 4));
    cyc("t5_b2", 0, 3, 0, 0, pk(1, 1, 0, 1, 0, 2));
    cyc("t5_bdone", 0, 3, 0, 0, pk(1, 0, 0, 0, 1, 0));
    cyc("t5_bidle", 0, 3, 0, 0, ZERO);

    // reset mid-RUN, reset beats start, then clean restart
    cyc("t6_start", 1, 8, 0, 0, ZERO);
    cyc("t6_v0", 0, 8, 0, 0, pk(1, 1, 1, 0, 0, 0));
    cyc("t6_v1", 0, 8, 0, 0, pk(1, 1, 0, 0, 0, 4));
    rst = 1'b1;
    cyc("t6_v2", 0, 8, 0, 0, pk(1, 1, 0, 0, 0, 2));
    cyc("t6_rst", 1, 8, 0, 0, ZERO);
    rst = 1'b0;
    cyc("t6_idle", 1, 3, 0, 0, ZERO);
    cyc("t6_n0", 0, 3, 0, 0, pk(1, 1, 1, 0, 0, 0));
    cyc("t6_n1", 0, 3, 0, 0, pk(1, 1, 0, 0, 0, 4));
    cyc("t6_n2", 0, 3, 0, 0, pk(1, 1, 0, 1, 0, 2));
    cyc("t6_ndone", 0, 3, 0, 0, pk(1, 0, 0, 0, 1, 0));
    cyc("t6_nidle", 0, 3, 0, 0, ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
